// File: rtl/queue_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package queue_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int N_REQ_DEF     = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 4;

   // A single producer still needs a one-bit pointer.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/queue_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter; slave is the arbiter view.
interface queue_wr_arbiter_if
   import queue_wr_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] data_in;
   logic                    fifo_full;
   logic [N_REQ-1:0]        ack;
   logic [N_REQ-1:0]        grant;
   logic                    fifo_wr_en;
   logic [DATA_W-1:0]       fifo_din;
   logic                    busy;

   modport master (
      output req, data_in, fifo_full,
      input  ack, grant, fifo_wr_en, fifo_din, busy
   );

   modport slave (
      input  req, data_in, fifo_full,
      output ack, grant, fifo_wr_en, fifo_din, busy
   );
endinterface

// File: rtl/queue_wr_arbiter_rr_pick.sv
// Rotating-priority search: first set req bit at or after start_i, modulo N_REQ.
// Purely combinational; no backpressure.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] start_i,
   output logic [N_REQ-1:0] win_o,
   output logic             vld_o
);
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = PTR_W'((int'(start_i) + k) % N_REQ);
         if (!found && req_i[idx]) begin
            win_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign vld_o = found;
endmodule

// File: rtl/queue_wr_arbiter.sv
// Round-robin burst arbiter for one FIFO write port; ack/write are zero-latency.
// fifo_full stalls the owner's burst without ending it; grant moves only at burst end.
module queue_wr_arbiter
   import queue_wr_arbiter_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic               clk,
   input  logic               rst,
   queue_wr_arbiter_if.slave  bus
);
   localparam int PTR_W = ptr_w(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [PTR_W-1:0]   owner, owner_nxt, pick_start;
   logic [N_REQ-1:0]   ack, pick_win;
   logic               pick_vld, last_beat, burst_end;
   logic [DATA_W-1:0]  din;

   always_comb begin
      owner = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant_q[i]) owner = PTR_W'(i);
   end

   assign owner_nxt  = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
   assign ack        = grant_q & bus.req & {N_REQ{~bus.fifo_full}};
   assign last_beat  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
   assign burst_end  = (state_q == BURST) &&
                       (!bus.req[owner] || (ack[owner] && last_beat));
   // Searching from owner+1 makes the current owner the last candidate.
   assign pick_start = (state_q == BURST) ? owner_nxt : rr_ptr_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i   (bus.req),
      .start_i (pick_start),
      .win_o   (pick_win),
      .vld_o   (pick_vld)
   );

   always_comb begin
      din = '0;
      for (int i = 0; i < N_REQ; i++)
         if (ack[i]) din = bus.data_in[i*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d    = BURST;
               grant_d    = pick_win;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (burst_end) begin
               rr_ptr_d   = owner_nxt;
               beat_cnt_d = '0;
               if (pick_vld) begin
                  grant_d = pick_win;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (ack[owner]) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign bus.ack        = ack;
   assign bus.grant      = grant_q;
   assign bus.fifo_wr_en = |ack;
   assign bus.fifo_din   = din;
   assign bus.busy       = (state_q == BURST);
endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Scenario tasks plus a randomized run checked against a queue-level arbitration model.
module tb_queue_wr_arbiter;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXB = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [DW-1:0] words [N];

   queue_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

   queue_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BURST (MAXB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 idle), words taken this burst, rotation pointer.
   int m_owner;
   int m_beats;
   int m_ptr;

   function automatic void model_reset();
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic f);
      bit took, done;
      done = 1'b1;
      if (m_owner >= 0) begin
         took = r[m_owner] && !f;
         if (took) m_beats++;
         done = !r[m_owner] || (took && m_beats == MAXB);
         if (done) m_ptr = (m_owner + 1) % N;
      end
      if (done) begin
         m_owner = -1;
         m_beats = 0;
         for (int k = 0; k < N; k++)
            if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
   endfunction

   task automatic put_words();
      for (int i = 0; i < N; i++) bus.data_in[i*DW +: DW] = words[i];
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req = '0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'b1111;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < N; i++) words[i] = 8'hA0 + 8'(i);
      put_words();
      #3;
      n_checks++;
      if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++;
      if (bus.ack !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
         n_errors++; $display("FAIL reset_ack got ack=%b wr_en=%b want 0000/0", bus.ack, bus.fifo_wr_en);
      end
      n_checks++;
      if (bus.fifo_din !== 8'h00) begin n_errors++; $display("FAIL reset_din got %h want 00", bus.fifo_din); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.req = '0;
   endtask

   task automatic test_single_producer();
      logic [DW-1:0] w;
      logic [DW-1:0] got [$];
      int gaps;
      apply_reset();
      w = 8'h11;
      gaps = 0;
      @(negedge clk);
      bus.req = 4'b0010; words[1] = w; put_words(); #1;
      n_checks++;
      if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL single_pre_grant got %b want 0000", bus.grant); end
      for (int c = 0; c < 20 && got.size() < 6; c++) begin
         @(negedge clk);
         words[1] = w; put_words(); #1;
         if (c == 0) begin
            n_checks++;
            if (bus.grant !== 4'b0010) begin n_errors++; $display("FAIL single_grant got %b want 0010", bus.grant); end
         end
         if (bus.grant !== 4'b0010) gaps++;
         if (bus.ack[1]) begin got.push_back(bus.fifo_din); w = w + 8'h01; end
      end
      n_checks++;
      if (got.size() != 6) begin n_errors++; $display("FAIL single_count got %0d want 6", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== 8'h11 + 8'(i)) begin n_errors++; $display("FAIL single_word%0d got %h want %h", i, got[i], 8'h11 + 8'(i)); end
      end
      n_checks++;
      if (gaps != 0) begin n_errors++; $display("FAIL single_gap got %0d idle cycles want 0", gaps); end
      @(negedge clk);
      bus.req = '0;
   endtask

   task automatic test_round_robin();
      int owners [$];
      int stalls, src;
      apply_reset();
      stalls = 0;
      for (int i = 0; i < N; i++) words[i] = {4'(i), 4'hA};
      @(negedge clk);
      bus.req = 4'b1111; put_words();
      for (int c = 0; c < 40 && owners.size() < 20; c++) begin
         @(negedge clk); #1;
         if (bus.fifo_wr_en) begin
            src = -1;
            for (int i = 0; i < N; i++) if (bus.ack[i]) src = i;
            owners.push_back(src);
            n_checks++;
            if (src < 0 || bus.fifo_din !== {4'(src), 4'hA}) begin
               n_errors++; $display("FAIL rr_din got %h from %0d", bus.fifo_din, src);
            end
         end else if (owners.size() > 0) stalls++;
      end
      n_checks++;
      if (owners.size() != 20) begin n_errors++; $display("FAIL rr_count got %0d want 20", owners.size()); end
      for (int k = 0; k < owners.size(); k++) begin
         n_checks++;
         if (owners[k] != (k / MAXB) % N) begin
            n_errors++; $display("FAIL rr_order write%0d got P%0d want P%0d", k, owners[k], (k / MAXB) % N);
         end
      end
      n_checks++;
      if (stalls != 0) begin n_errors++; $display("FAIL rr_gap got %0d want 0", stalls); end
      bus.req = '0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < N; i++) words[i] = 8'h20 + 8'(i);
      put_words();
      @(negedge clk);
      bus.req = 4'b0100;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (bus.ack !== 4'b0100 || bus.fifo_din !== 8'h22) begin
            n_errors++; $display("FAIL bp_beat%0d got ack=%b din=%h want 0100/22", c, bus.ack, bus.fifo_din);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.fifo_full = 1'b1; bus.req = 4'b0101; #1;
         n_checks++;
         if (bus.grant !== 4'b0100 || bus.ack !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
            n_errors++; $display("FAIL bp_stall%0d got grant=%b ack=%b wr_en=%b want 0100/0000/0", c, bus.grant, bus.ack, bus.fifo_wr_en);
         end
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus.fifo_full = 1'b0; #1;
         n_checks++;
         if (bus.ack !== 4'b0100) begin n_errors++; $display("FAIL bp_resume%0d got ack=%b want 0100", c, bus.ack); end
      end
      @(negedge clk); #1;
      n_checks++;
      if (bus.grant !== 4'b0001 || bus.ack !== 4'b0001) begin
         n_errors++; $display("FAIL bp_handover got grant=%b ack=%b want 0001/0001", bus.grant, bus.ack);
      end
      bus.req = '0;
   endtask

   task automatic test_early_release();
      apply_reset();
      @(negedge clk);
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = 4'b1010; #1;
      n_checks++;
      if (bus.grant !== 4'b0010 || bus.ack !== 4'b0010) begin
         n_errors++; $display("FAIL early_beat got grant=%b ack=%b want 0010/0010", bus.grant, bus.ack);
      end
      @(negedge clk);
      bus.req = 4'b1000; #1;
      n_checks++;
      if (bus.grant !== 4'b0010 || bus.fifo_wr_en !== 1'b0) begin
         n_errors++; $display("FAIL early_drop got grant=%b wr_en=%b want 0010/0", bus.grant, bus.fifo_wr_en);
      end
      @(negedge clk); #1;
      n_checks++;
      if (bus.grant !== 4'b1000) begin n_errors++; $display("FAIL early_grant got %b want 1000", bus.grant); end
      n_checks++;
      if (dut.rr_ptr_q !== 2'd2) begin n_errors++; $display("FAIL early_ptr got %0d want 2", dut.rr_ptr_q); end
      bus.req = '0;
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      @(negedge clk);
      bus.req = 4'b1000;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (bus.ack !== 4'b1000) begin n_errors++; $display("FAIL mid_pre got ack=%b want 1000", bus.ack); end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.grant !== 4'b0000 || bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         n_errors++; $display("FAIL mid_async got grant=%b wr_en=%b busy=%b want 0000/0/0", bus.grant, bus.fifo_wr_en, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0; bus.req = 4'b1111; #1;
      n_checks++;
      if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL mid_release got %b want 0000", bus.grant); end
      @(negedge clk); #1;
      n_checks++;
      if (bus.grant !== 4'b0001) begin n_errors++; $display("FAIL mid_restart got %b want 0001", bus.grant); end
      bus.req = '0;
   endtask

   task automatic test_random();
      logic [N-1:0]  exp_grant, exp_ack, last_ack;
      logic [DW-1:0] exp_din;
      int ack_total, wr_total, bad_cycles;
      apply_reset();
      ack_total = 0; wr_total = 0; bad_cycles = 0; last_ack = '0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!bus.req[i] || last_ack[i]) words[i] = 8'($urandom);
            if (bus.req[i]) begin
               if ($urandom_range(7) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(3) == 0) bus.req[i] = 1'b1;
         end
         bus.fifo_full = ($urandom_range(3) == 0);
         put_words();
         #1;
         exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
         exp_ack   = exp_grant & bus.req & {N{~bus.fifo_full}};
         exp_din   = (exp_ack != 0) ? words[m_owner] : 8'h00;
         n_checks++;
         if (bus.grant !== exp_grant || bus.ack !== exp_ack || bus.fifo_din !== exp_din ||
             bus.fifo_wr_en !== (exp_ack != 0) || bus.busy !== (m_owner >= 0)) begin
            n_errors++;
            if (bad_cycles < 10)
               $display("FAIL rand_c%0d got grant=%b ack=%b din=%h busy=%b want %b/%b/%h/%b",
                        c, bus.grant, bus.ack, bus.fifo_din, bus.busy, exp_grant, exp_ack, exp_din, m_owner >= 0);
            bad_cycles++;
         end
         n_checks++;
         if (!$onehot0(bus.ack) || !$onehot0(bus.grant) || dut.beat_cnt_q >= 3'(MAXB)) begin
            n_errors++; $display("FAIL rand_prop_c%0d ack=%b grant=%b beats=%0d", c, bus.ack, bus.grant, dut.beat_cnt_q);
         end
         ack_total += $countones(bus.ack);
         if (bus.fifo_wr_en) wr_total++;
         last_ack = bus.ack;
         model_step(bus.req, bus.fifo_full);
      end
      n_checks++;
      if (ack_total != wr_total) begin n_errors++; $display("FAIL rand_counts got acks=%0d writes=%0d", ack_total, wr_total); end
      bus.req = '0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      test_reset();
      test_single_producer();
      test_round_robin();
      test_backpressure();
      test_early_release();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
